// File: rtl/instr_sequencer.sv
// Instruction register, decoder and Moore control FSM for the register file/datapath.
// Optional `SEQ_ILLEGAL_FLAG_EN adds a sticky `illegal` output.
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
`ifdef SEQ_ILLEGAL_FLAG_EN
  ,
  output logic        illegal
`endif
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_COMPUTE,
    S_WR_REG,
    S_WR_IMM
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;
  logic       is_movi;
  logic       is_movr;
  logic       is_alu;
  logic       is_mvn;
  logic       is_cmp;
  logic       is_two;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_two  = is_alu && !is_mvn;

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign shift  = ir[4:3];
  assign ALUop  = is_alu ? op : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= 16'h0000;
    end else if (state == S_WAIT && load) begin
      ir <= in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT:    state_nx = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        unique case (1'b1)
          is_movi:          state_nx = S_WR_IMM;
          is_movr, is_mvn:  state_nx = S_GET_B;
          is_two:           state_nx = S_GET_A;
          default:          state_nx = S_WAIT;
        endcase
      end
      S_GET_A:   state_nx = S_GET_B;
      S_GET_B:   state_nx = S_COMPUTE;
      S_COMPUTE: state_nx = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_REG:  state_nx = S_WAIT;
      S_WR_IMM:  state_nx = S_WAIT;
      default:   state_nx = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    unique case (state)
      S_WAIT: w = 1'b1;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_COMPUTE: begin
        loadc = 1'b1;
        asel  = is_movr;
        loads = is_cmp;
      end
      S_WR_REG: begin
        writenum = rd;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        writenum = rn;
        write    = 1'b1;
        vsel     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SEQ_ILLEGAL_FLAG_EN
  logic legal;
  assign legal = is_movi | is_movr | is_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal <= 1'b0;
    end else if (state == S_DECODE && !legal) begin
      illegal <= 1'b1;
    end else if (state == S_WAIT && s) begin
      illegal <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle expected outputs queued at
// stimulus time and drained against the DUT at each falling edge.
module tb_instr_sequencer;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        vsel;
    logic [1:0]  shift;
    logic [1:0]  alu;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } obs_t;

  logic        clk;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  alu_op;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
`ifdef SEQ_ILLEGAL_FLAG_EN
  logic        illegal;
`endif

  obs_t obs;
  obs_t q[$];
  int   errors;
  int   checks;

  instr_sequencer dut (
    .clk(clk),
    .reset(reset),
    .s(s),
    .load(load),
    .in(in),
    .w(w),
    .readnum(readnum),
    .writenum(writenum),
    .write(write),
    .loada(loada),
    .loadb(loadb),
    .loadc(loadc),
    .loads(loads),
    .asel(asel),
    .bsel(bsel),
    .vsel(vsel),
    .shift(shift),
    .ALUop(alu_op),
    .sximm8(sximm8),
    .sximm5(sximm5)
`ifdef SEQ_ILLEGAL_FLAG_EN
    ,
    .illegal(illegal)
`endif
  );

  assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, shift, alu_op, sximm8, sximm5};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t base(input logic [15:0] ir);
    obs_t e;
    e        = '0;
    e.shift  = ir[4:3];
    e.alu    = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
    e.sximm8 = {{8{ir[7]}}, ir[7:0]};
    e.sximm5 = {{11{ir[4]}}, ir[4:0]};
    return e;
  endfunction

  task automatic push_seq(input logic [15:0] ir);
    obs_t e;
    logic [2:0] opc;
    logic [1:0] op;
    logic movi, movr, alu, mvn, cmp;
    opc  = ir[15:13];
    op   = ir[12:11];
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    alu  = (opc == 3'b101);
    mvn  = alu && (op == 2'b11);
    cmp  = alu && (op == 2'b01);
    q.push_back(base(ir));
    if (movi) begin
      e = base(ir);
      e.writenum = ir[10:8];
      e.write = 1'b1;
      e.vsel = 1'b1;
      q.push_back(e);
    end else if (movr || alu) begin
      if (alu && !mvn) begin
        e = base(ir);
        e.readnum = ir[10:8];
        e.loada = 1'b1;
        q.push_back(e);
      end
      e = base(ir);
      e.readnum = ir[2:0];
      e.loadb = 1'b1;
      q.push_back(e);
      e = base(ir);
      e.loadc = 1'b1;
      e.asel = movr;
      e.loads = cmp;
      q.push_back(e);
      if (!cmp) begin
        e = base(ir);
        e.writenum = ir[7:5];
        e.write = 1'b1;
        q.push_back(e);
      end
    end
    e = base(ir);
    e.w = 1'b1;
    q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int k;
    obs_t e;
    k = 0;
    while (q.size() > 0) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("%s.cyc%0d", tag, k), 64'(obs), 64'(e));
      k++;
    end
    s = 1'b0;
    load = 1'b0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    in = v;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic start(input bit hold);
    s = 1'b1;
    @(posedge clk);
    #1 if (!hold) s = 1'b0;
  endtask

  initial begin
    obs_t e;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    s = 1'b0;
    load = 1'b0;
    in = 16'h0000;
    #12;
    e = base(16'h0000);
    e.w = 1'b1;
    chk("reset_outputs", 64'(obs), 64'(e));
`ifdef SEQ_ILLEGAL_FLAG_EN
    chk("reset_illegal", 64'(illegal), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    load_ir(16'hD007);
    chk("movi7_sximm8", 64'(sximm8), 64'h0007);
    push_seq(16'hD007);
    start(1'b0);
    drain("mov_r0_7");

    load_ir(16'hD1FE);
    chk("movim2_sximm8", 64'(sximm8), 64'hFFFE);
    push_seq(16'hD1FE);
    start(1'b0);
    drain("mov_r1_m2");

    load_ir(16'hA148);
    push_seq(16'hA148);
    start(1'b0);
    drain("add");

    load_ir(16'hA801);
    push_seq(16'hA801);
    start(1'b0);
    in = 16'hFFFF;
    load = 1'b1;
    drain("cmp_load_ignored");

    load_ir(16'hB860);
    push_seq(16'hB860);
    push_seq(16'hB860);
    start(1'b1);
    drain("mvn_s_held");

    load_ir(16'hB193);
    push_seq(16'hB193);
    start(1'b0);
    drain("and");

    load_ir(16'hE000);
    push_seq(16'hE000);
    start(1'b0);
    drain("illegal_e000");
`ifdef SEQ_ILLEGAL_FLAG_EN
    chk("illegal_set", 64'(illegal), 64'd1);
`endif

    in = 16'hC0A2;
    load = 1'b1;
    s = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    s = 1'b0;
`ifdef SEQ_ILLEGAL_FLAG_EN
    chk("illegal_cleared", 64'(illegal), 64'd0);
`endif
    push_seq(16'hC0A2);
    drain("movr_load_and_s");

    load_ir(16'hD007);
    start(1'b0);
    @(posedge clk);
    #1 chk("wrimm_write", 64'(write), 64'd1);
    reset = 1'b1;
    #1 chk("reset_write_async", 64'(write), 64'd0);
    chk("reset_w_async", 64'(w), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    load_ir(16'hA148);
    start(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 chk("getb_readnum", 64'(readnum), 64'd0);
    chk("getb_loadb", 64'(loadb), 64'd1);
    reset = 1'b1;
    #1;
    e = base(16'h0000);
    e.w = 1'b1;
    chk("mid_reset_outputs", 64'(obs), 64'(e));
    @(negedge clk);
    reset = 1'b0;
    push_seq(16'h0000);
    start(1'b0);
    drain("post_reset_ir0");
`ifdef SEQ_ILLEGAL_FLAG_EN
    chk("ir0_illegal", 64'(illegal), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
